// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory for an HMMM-style core.
// After reset a host streams big-endian program bytes into the memory while
// the core is held in reset. Once the load completes the core is released
// and its memory port is served with a 1-cycle registered read.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WORD  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [7:0]      load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            cpu_reset,
  output logic            loaded,
  output logic [8:0]      load_words,
  input  logic [7:0]      adr,
  input  logic            memWrite,
  input  logic [7:0]      WriteData,
  output logic [WORD-1:0] ReadData
);

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Last writable word; reaching it during a load ends the load.
  localparam logic [7:0] LAST_PTR = 8'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  load_words_q, load_words_d;
  logic        loaded_q, loaded_d;

  // Single write port shared between the boot loader and the running core.
  logic            mem_we;
  logic [7:0]      mem_waddr;
  logic [WORD-1:0] mem_wdata;

  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] read_data_q;

  logic accept;

  assign load_ready = (state_q != RUN);
  assign accept     = load_valid & load_ready;
  assign loaded     = loaded_q;
  assign cpu_reset  = ~loaded_q;
  assign load_words = load_words_q;
  assign ReadData   = read_data_q;

  // Next-state, loader bookkeeping and memory write-port selection.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hi_d         = hi_q;
    load_words_d = load_words_q;
    loaded_d     = loaded_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = '0;

    case (state_q)
      LOAD_HI: begin
        if (accept) begin
          hi_d = load_data;
          if (load_last) begin
            // Odd-length program: final word padded with a zero low byte.
            mem_we       = 1'b1;
            mem_wdata    = WORD'({load_data, 8'h00});
            load_words_d = load_words_q + 9'd1;
            state_d      = RUN;
            loaded_d     = 1'b1;
          end else begin
            state_d = LOAD_LO;
          end
        end
      end

      LOAD_LO: begin
        if (accept) begin
          mem_we       = 1'b1;
          mem_wdata    = WORD'({hi_q, load_data});
          ptr_d        = ptr_q + 8'd1;
          load_words_d = load_words_q + 9'd1;
          // A full memory terminates the load even without load_last.
          if (load_last || (ptr_q == LAST_PTR)) begin
            state_d  = RUN;
            loaded_d = 1'b1;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end

      RUN: begin
        if (memWrite) begin
          mem_we    = 1'b1;
          mem_waddr = adr;
          mem_wdata = WORD'(WriteData);
        end
      end

      default: begin
        state_d  = LOAD_HI;
        loaded_d = 1'b0;
      end
    endcase
  end

  // FSM and loader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_HI;
      ptr_q        <= 8'd0;
      hi_q         <= 8'd0;
      load_words_q <= 9'd0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hi_q         <= hi_d;
      load_words_q <= load_words_d;
      loaded_q     <= loaded_d;
    end
  end

  // Memory array (never reset) with read-first registered read port; the
  // output register is cleared outside RUN so the core sees 0 while loading.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (reset || (state_q != RUN)) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= mem[adr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: boot loads of several shapes, RUN
// reads/writes checked through an expected-read queue, reset behaviour.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic        loaded;
  logic [8:0]  load_words;
  logic [7:0]  adr;
  logic        memWrite;
  logic [7:0]  WriteData;
  logic [15:0] ReadData;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] exp_mem [256];
  logic [15:0] sb_q [$];

  mem_responder #(.DEPTH(256), .WORD(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_reset  (cpu_reset),
    .loaded     (loaded),
    .load_words (load_words),
    .adr        (adr),
    .memWrite   (memWrite),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    n = 0;
    while (!load_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", {15'd0, load_ready}, 16'd1);
    tick();
    $display("load byte %h last=%0b load_words=%0d loaded=%0b", d, last, load_words, loaded);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // One RUN-mode cycle; optionally queue and compare the expected read.
  task automatic run_cycle(input logic [7:0] a, input logic we, input logic [7:0] wd, input logic chk);
    logic [15:0] e;
    adr       = a;
    memWrite  = we;
    WriteData = wd;
    if (chk) sb_q.push_back(exp_mem[a]);
    if (we) exp_mem[a] = {8'h00, wd};
    tick();
    memWrite = 1'b0;
    if (chk) begin
      e = sb_q.pop_front();
      check("read_data", ReadData, e);
      $display("run adr=%h we=%0b wd=%h ReadData=%h expected=%h", a, we, wd, ReadData, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    int c0;
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    adr = 8'h00; memWrite = 1'b0; WriteData = 8'h00;
    for (int i = 0; i < 256; i++) exp_mem[i] = 'x;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_loaded",     {15'd0, loaded},     16'd0);
    check("rst_cpu_reset",  {15'd0, cpu_reset},  16'd1);
    check("rst_load_ready", {15'd0, load_ready}, 16'd1);
    check("rst_load_words", {7'd0, load_words},  16'd0);
    check("rst_read_data",  ReadData,            16'd0);

    // 4-byte load 12 34 AB CD
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    check("pre_last_loaded", {15'd0, loaded}, 16'd0);
    send_byte(8'hCD, 1'b1);
    exp_mem[0] = 16'h1234; exp_mem[1] = 16'hABCD;
    check("l4_loaded",     {15'd0, loaded},     16'd1);
    check("l4_cpu_reset",  {15'd0, cpu_reset},  16'd0);
    check("l4_load_ready", {15'd0, load_ready}, 16'd0);
    check("l4_load_words", {7'd0, load_words},  16'd2);
    check("l4_rd_zero",    ReadData,            16'd0);
    run_cycle(8'd1, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd0, 1'b0, 8'h00, 1'b1);

    // RUN writes: write-then-read and read-first same-cycle write
    run_cycle(8'd7, 1'b1, 8'h5A, 1'b0);
    run_cycle(8'd7, 1'b1, 8'hFF, 1'b1);
    run_cycle(8'd7, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd5, 1'b1, 8'h3C, 1'b0);
    run_cycle(8'd5, 1'b0, 8'h00, 1'b1);

    // Reset in RUN, then odd 3-byte load
    reset = 1'b1;
    tick();
    check("runrst_cpu_reset",  {15'd0, cpu_reset}, 16'd1);
    check("runrst_loaded",     {15'd0, loaded},    16'd0);
    check("runrst_read_data",  ReadData,           16'd0);
    check("runrst_load_words", {7'd0, load_words}, 16'd0);
    reset = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    exp_mem[0] = 16'h0102; exp_mem[1] = 16'h0300;
    check("odd_loaded",     {15'd0, loaded},    16'd1);
    check("odd_load_words", {7'd0, load_words}, 16'd2);
    run_cycle(8'd1, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd0, 1'b0, 8'h00, 1'b1);

    // Gapped load with memWrite held high on address 5
    do_reset();
    memWrite = 1'b1; adr = 8'd5; WriteData = 8'h77;
    b0 = 8'h11;
    for (int i = 0; i < 4; i++) begin
      send_byte(b0, (i == 3));
      if (i < 3) begin
        tick();
        check("gap_load_words", {7'd0, load_words}, 16'((i + 1) / 2));
        check("gap_read_data",  ReadData,           16'd0);
      end
      b0 = b0 + 8'h11;
    end
    memWrite = 1'b0;
    exp_mem[0] = 16'h1122; exp_mem[1] = 16'h3344;
    check("gap_load_words_end", {7'd0, load_words}, 16'd2);
    run_cycle(8'd5, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd0, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd1, 1'b0, 8'h00, 1'b1);

    // Reset mid-load after 3 bytes, then reload EE FF
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    check("abort_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    do_reset();
    check("abort_cpu_reset_rst", {15'd0, cpu_reset}, 16'd1);
    send_byte(8'hEE, 1'b0);
    check("abort_cpu_reset_mid", {15'd0, cpu_reset}, 16'd1);
    send_byte(8'hFF, 1'b1);
    exp_mem[0] = 16'hEEFF;
    check("abort_load_words", {7'd0, load_words}, 16'd1);
    run_cycle(8'd0, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd1, 1'b0, 8'h00, 1'b1);

    // Full 512-byte load without load_last
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 256; k++) begin
      b0 = 8'(k * 7 + 3);
      b1 = 8'(k * 13 + 5);
      load_valid = 1'b1; load_data = b0; load_last = 1'b0;
      tick();
      load_data = b1;
      tick();
      exp_mem[k] = {b0, b1};
    end
    load_valid = 1'b0;
    $display("full load done load_words=%0d loaded=%0b", load_words, loaded);
    check("full_cycles",     16'(cyc - c0),       16'd512);
    check("full_loaded",     {15'd0, loaded},     16'd1);
    check("full_load_words", {7'd0, load_words},  16'd256);
    check("full_load_ready", {15'd0, load_ready}, 16'd0);
    load_valid = 1'b1; load_data = 8'h99; load_last = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("extra_load_words", {7'd0, load_words}, 16'd256);
    check("extra_loaded",     {15'd0, loaded},    16'd1);
    load_valid = 1'b0; load_last = 1'b0;
    run_cycle(8'd255, 1'b0, 8'h00, 1'b1);
    run_cycle(8'd0,   1'b0, 8'h00, 1'b1);
    run_cycle(8'd128, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
